// File: rtl/serial_window_feeder.sv
// ---------------------------------------------------------------------------
// serial_window_feeder
//
// Upstream stage for a 4-input pattern-detect primitive (A,B,C,D -> Y).
// A qualified serial bit stream is shifted into a 4-bit sliding window that
// is presented as A (oldest) .. D (newest). The detector's Y comes back as
// hit_in. A hit is counted only in the cycle right after the window shifted
// into a full state, so each window is counted at most once.
//
// Parameters:
//   CNT_W      width of the saturating hit counter
//   NONOVERLAP 1 = restart window fill after each counted hit,
//              0 = overlapping matches allowed
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous clear of window, fill, counter and flags
//   din        serial data bit
//   din_valid  din qualifier, one bit consumed per cycle while high
//   A,B,C,D    window bits 3..0 (A oldest, D newest)
//   win_valid  window holds 4 bits received since last reset/clear/flush
//   win_new    one-cycle pulse, window shifted on the previous edge
//   hit_in     Y from the downstream detector
//   hit_pulse  one-cycle pulse, a hit was counted
//   hit_count  number of counted hits (saturating)
//   hit_ovf    sticky, a hit arrived while hit_count was saturated
//
// Build option:
//   DIN_SYNC_EN  when defined, din/din_valid pass through a 2-flop
//                synchronizer first, delaying all shift-related outputs by
//                two cycles. clr is used directly in either build.
// ---------------------------------------------------------------------------
module serial_window_feeder #(
    parameter int CNT_W      = 8,
    parameter int NONOVERLAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             win_valid,
    output logic             win_new,
    input  logic             hit_in,
    output logic             hit_pulse,
    output logic [CNT_W-1:0] hit_count,
    output logic             hit_ovf
);

    localparam logic [2:0]       FILL_FULL = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic       shift_din;
    logic       shift_en;
    logic [3:0] window;
    logic [2:0] fill;
    logic [2:0] fill_next;
    logic       count_en;
    logic       hit;
    logic       flush;

`ifdef DIN_SYNC_EN
    logic [1:0] din_sync;
    logic [1:0] valid_sync;

    // Two-stage synchronizer for the serial input and its qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_sync   <= 2'b00;
            valid_sync <= 2'b00;
        end else begin
            din_sync   <= {din_sync[0], din};
            valid_sync <= {valid_sync[0], din_valid};
        end
    end

    assign shift_din = din_sync[1];
    assign shift_en  = valid_sync[1];
`else
    assign shift_din = din;
    assign shift_en  = din_valid;
`endif

    assign {A, B, C, D} = window;

    // Only the first cycle after a shift into a full window is eligible,
    // so a window held for many cycles is counted once.
    assign count_en = win_new & win_valid;
    assign hit      = count_en & hit_in;
    assign flush    = hit & (NONOVERLAP != 0);

    // A flush restarts the fill; a bit shifted on the same edge is the
    // first bit of the next window.
    always_comb begin
        fill_next = fill;
        if (flush) begin
            fill_next = shift_en ? 3'd1 : 3'd0;
        end else if (shift_en && (fill != FILL_FULL)) begin
            fill_next = fill + 3'd1;
        end
    end

    // Window, fill and status flags. clr takes priority over shift and hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window    <= 4'b0000;
            fill      <= 3'd0;
            win_valid <= 1'b0;
            win_new   <= 1'b0;
            hit_pulse <= 1'b0;
            hit_count <= '0;
            hit_ovf   <= 1'b0;
        end else if (clr) begin
            window    <= 4'b0000;
            fill      <= 3'd0;
            win_valid <= 1'b0;
            win_new   <= 1'b0;
            hit_pulse <= 1'b0;
            hit_count <= '0;
            hit_ovf   <= 1'b0;
        end else begin
            if (shift_en) begin
                window <= {window[2:0], shift_din};
            end
            win_new   <= shift_en;
            fill      <= fill_next;
            win_valid <= (fill_next == FILL_FULL);
            hit_pulse <= hit;
            if (hit) begin
                if (hit_count != CNT_MAX) begin
                    hit_count <= hit_count + 1'b1;
                end else begin
                    hit_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_window_feeder
//
// Two instances share stimulus: dut0 allows overlapping matches with an
// 8-bit counter, dut1 flushes after each hit with a 2-bit counter. Each
// instance drives its own model of the 0110 detector back into hit_in.
// ---------------------------------------------------------------------------
module tb_serial_window_feeder;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       din;
    logic       din_valid;

    logic       a0, b0, c0, d0, win_valid0, win_new0, hit0, hit_pulse0, hit_ovf0;
    logic [7:0] hit_count0;
    logic       a1, b1, c1, d1, win_valid1, win_new1, hit1, hit_pulse1, hit_ovf1;
    logic [1:0] hit_count1;

    int check_count;
    int pass_count;

    // Downstream detector: fires on A=0 B=1 C=1 D=0.
    assign hit0 = ~a0 & b0 & c0 & ~d0;
    assign hit1 = ~a1 & b1 & c1 & ~d1;

    serial_window_feeder #(.CNT_W(8), .NONOVERLAP(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
        .A(a0), .B(b0), .C(c0), .D(d0),
        .win_valid(win_valid0), .win_new(win_new0), .hit_in(hit0),
        .hit_pulse(hit_pulse0), .hit_count(hit_count0), .hit_ovf(hit_ovf0)
    );

    serial_window_feeder #(.CNT_W(2), .NONOVERLAP(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .win_valid(win_valid1), .win_new(win_new1), .hit_in(hit1),
        .hit_pulse(hit_pulse1), .hit_count(hit_count1), .hit_ovf(hit_ovf1)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic bit_val, input logic vld);
        din       = bit_val;
        din_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [15:0] ovf_stream;
        check_count = 0;
        pass_count  = 0;
        rst         = 1'b1;
        clr         = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        checkOutput("rst_win0",   {a0, b0, c0, d0}, 4'b0000);
        checkOutput("rst_flags0", {win_valid0, win_new0, hit_pulse0, hit_ovf0}, 4'b0000);
        checkOutput("rst_cnt0",   hit_count0, 8'd0);
        checkOutput("rst_cnt1",   hit_count1, 2'd0);
        rst = 1'b0;

        // Baseline window 0110.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("fill3_valid0", win_valid0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("w4_win0",   {a0, b0, c0, d0}, 4'b0110);
        checkOutput("w4_valid0", win_valid0, 1'b1);
        checkOutput("w4_new0",   win_new0, 1'b1);
        checkOutput("w4_pulse0", hit_pulse0, 1'b0);
        checkOutput("w4_valid1", win_valid1, 1'b1);

        // Continue stream 1,1,0: hit counted on the edge after the 4th bit.
        applyStimulus(1'b1, 1'b1);
        checkOutput("h1_pulse0", hit_pulse0, 1'b1);
        checkOutput("h1_cnt0",   hit_count0, 8'd1);
        checkOutput("h1_pulse1", hit_pulse1, 1'b1);
        checkOutput("h1_cnt1",   hit_count1, 2'd1);
        checkOutput("h1_flush1", win_valid1, 1'b0);
        checkOutput("h1_win1",   {a1, b1, c1, d1}, 4'b1101);
        applyStimulus(1'b1, 1'b1);
        checkOutput("h1_end0",   hit_pulse0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("w7_win0",   {a0, b0, c0, d0}, 4'b0110);
        checkOutput("w7_valid1", win_valid1, 1'b0);

        // Idle: overlapping window counted once, then held with hit_in high.
        applyStimulus(1'b0, 1'b0);
        checkOutput("h2_pulse0", hit_pulse0, 1'b1);
        checkOutput("h2_cnt0",   hit_count0, 8'd2);
        checkOutput("h2_pulse1", hit_pulse1, 1'b0);
        checkOutput("h2_cnt1",   hit_count1, 2'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("hold_hit0",  hit0, 1'b1);
        checkOutput("hold_new0",  win_new0, 1'b0);
        checkOutput("hold_cnt0",  hit_count0, 8'd2);
        checkOutput("hold_win0",  {a0, b0, c0, d0}, 4'b0110);
        checkOutput("hold_pls0",  hit_pulse0, 1'b0);

        // Fresh bits for dut1: first one completes fill with 1100.
        applyStimulus(1'b0, 1'b1);
        checkOutput("rf_valid1", win_valid1, 1'b1);
        checkOutput("rf_win1",   {a1, b1, c1, d1}, 4'b1100);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rf_win1b",  {a1, b1, c1, d1}, 4'b0110);
        applyStimulus(1'b0, 1'b0);
        checkOutput("h3_cnt0",   hit_count0, 8'd3);
        checkOutput("h3_cnt1",   hit_count1, 2'd2);
        checkOutput("h3_pulse1", hit_pulse1, 1'b1);
        checkOutput("h3_flush1", win_valid1, 1'b0);

        // Synchronous clear.
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0);
        clr = 1'b0;
        checkOutput("clr_cnt0", hit_count0, 8'd0);
        checkOutput("clr_cnt1", hit_count1, 2'd0);
        checkOutput("clr_win0", {a0, b0, c0, d0}, 4'b0000);

        // Four back-to-back 0110 windows: dut1 saturates at 3 and overflows.
        ovf_stream = 16'b0110_0110_0110_0110;
        for (int i = 15; i >= 0; i--) begin
            applyStimulus(ovf_stream[i], 1'b1);
            if (i == 0) begin
                checkOutput("pre_ovf_cnt1", hit_count1, 2'd3);
                checkOutput("pre_ovf_ovf1", hit_ovf1, 1'b0);
            end
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_cnt1",   hit_count1, 2'd3);
        checkOutput("ovf_ovf1",   hit_ovf1, 1'b1);
        checkOutput("ovf_pulse1", hit_pulse1, 1'b1);
        checkOutput("ovf_cnt0",   hit_count0, 8'd4);
        checkOutput("ovf_ovf0",   hit_ovf0, 1'b0);

        // clr wins over a simultaneous shift.
        clr = 1'b1;
        applyStimulus(1'b1, 1'b1);
        clr = 1'b0;
        checkOutput("clr2_ovf1", hit_ovf1, 1'b0);
        checkOutput("clr2_cnt1", hit_count1, 2'd0);
        checkOutput("clr2_win1", {a1, b1, c1, d1}, 4'b0000);
        checkOutput("clr2_new1", win_new1, 1'b0);

        // Asynchronous reset mid-stream discards the partial window.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mid_win0", {a0, b0, c0, d0}, 4'b0011);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_win0", {a0, b0, c0, d0}, 4'b0000);
        checkOutput("arst_new0", win_new0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("post_valid0", win_valid0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_cnt0", hit_count0, 8'd0);
        checkOutput("post_cnt1", hit_count1, 2'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/serial_window_feeder.md
Name: serial_window_feeder

Overview:
- Upstream stage for the 4-input pattern-detect primitive wrapper (A,B,C,D -> Y, fires on A=0 B=1 C=1 D=0).
- Deserializes a qualified serial bit stream into a 4-bit sliding window and drives it as A,B,C,D.
- Takes the detector's Y back as hit_in, qualifies and counts hits, and optionally enforces non-overlapping matches by flushing the window after a hit.

Parameters:
- CNT_W, 8: width of hit counter; saturates at 2^CNT_W-1.
- NONOVERLAP, 0: 1 = flush window fill after each counted hit; 0 = overlapping matches allowed.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of window, fill, counter and flags.
- din  input  1  serial data bit.
- din_valid  input  1  din qualifier; one bit is consumed per cycle while high.
- A  output  1  window bit 3, oldest received.
- B  output  1  window bit 2.
- C  output  1  window bit 1.
- D  output  1  window bit 0, newest received.
- win_valid  output  1  window holds 4 bits received since last reset, clear or flush.
- win_new  output  1  one-cycle pulse: window shifted on the previous edge.
- hit_in  input  1  Y from downstream detector (combinational from A..D).
- hit_pulse  output  1  registered, one cycle; a hit was counted.
- hit_count  output  CNT_W  number of counted hits.
- hit_ovf  output  1  sticky; a hit arrived while hit_count was saturated.

Behaviour:
- Reset (async, rst=1): A=B=C=D=0, fill=0, win_valid=0, win_new=0, hit_pulse=0, hit_count=0, hit_ovf=0.
- All state is registered; no combinational path from any input to any output.
- Shift: on an edge with din_valid=1, {A,B,C,D} <= {B,C,D,din}. win_new <= 1 on that edge, else 0.
- fill counter (0..4, internal):
  - Increments on each shift and saturates at 4.
  - win_valid = (fill==4), registered, so it rises on the same edge as the 4th shift.
- Hit qualification:
  - hit_in is evaluated only in cycles where win_new=1 && win_valid=1 (count_en).
  - Each window is therefore counted at most once, regardless of how long it is held.
- On a qualified hit edge:
  - hit_pulse <= 1.
  - If hit_count < max, hit_count increments; otherwise it holds at max and hit_ovf <= 1.
  - hit_pulse is 0 on all other edges.
- NONOVERLAP=1, qualified hit on the same edge:
  - fill <= 0, and win_valid drops on that edge.
  - Window bits A..D are not cleared.
  - If din_valid=1 on the same edge, the shift still occurs and fill <= 1, not 0.
- NONOVERLAP=0: fill is unaffected by hits.
- Latency: the 4th bit is sampled on edge N. A..D and win_valid update on N, hit_in settles in cycle N..N+1, and hit_pulse/hit_count update on edge N+1.
- clr=1 (sync):
  - Same values as reset on the next edge.
  - Has priority over shift and hit on that edge.
- rst asserted mid-stream: all state is lost immediately; the partial window is discarded.
- din_valid held low: window, fill and flags hold; win_new=0, so no counting.

Optional Feature:
- Macro DIN_SYNC_EN.
- Defined:
  - din and din_valid pass through a 2-flop synchronizer (reset to 0 by rst) before the shift logic.
  - All shift-related outputs are delayed by 2 cycles.
  - clr is not synchronized.
- Undefined: din/din_valid feed the shift logic directly, with the latency as stated in Behaviour.

Test Plan (DIN_SYNC_EN undefined unless stated):
- Reset, then din_valid=1 with bits 0,1,1,0 on consecutive cycles -> after 4th edge A..D=0110 and win_valid=1; next edge hit_pulse=1, hit_count=1.
- NONOVERLAP=0, stream 0,1,1,0,1,1,0 continuous -> hit_count=2 (windows at bits 4 and 7 overlap on shared 0); hit_pulse high exactly two cycles.
- NONOVERLAP=1, same stream -> hit_count=1; win_valid drops after first hit, refills after 4 more bits; second 0110 requires 4 fresh bits.
- Stream 0,1,1,0 then din_valid=0 for 10 cycles with hit_in held 1 -> hit_count stays 1 (win_new gating).
- CNT_W=2, feed 0110 windows non-overlapping 4 times -> hit_count=3, hit_ovf=1 after 4th hit; clr=1 -> all zero next edge.
- DIN_SYNC_EN defined, bits 0,1,1,0 -> win_valid rises 2 cycles later than the baseline case; assert rst mid-stream -> outputs 0 immediately, no hit counted.
